// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The opcode constants mirror the ALU_8bit decode so benches can build stimulus.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

endpackage

// File: rtl/ALU_8bit.sv
// Shared 8-bit combinational ALU. Cout is the ninth result bit: carry for
// ADD, borrow for SUB, shifted-out bit for SHL, 0 for the logic operations.
module ALU_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       Zero,
    output logic       Cout
);

    logic [8:0] wide_s;

    // Opcode decode into a 9-bit result carrying the flag bit on top.
    always_comb begin
        wide_s = 9'd0;
        case (ALU_Sel)
            3'd0:    wide_s = {1'b0, A} + {1'b0, B};
            3'd1:    wide_s = {1'b0, A} - {1'b0, B};
            3'd2:    wide_s = {1'b0, A & B};
            3'd3:    wide_s = {1'b0, A | B};
            3'd4:    wide_s = {1'b0, A ^ B};
            3'd5:    wide_s = {1'b0, ~A};
            3'd6:    wide_s = {A, 1'b0};
            3'd7:    wide_s = {2'b00, A[7:1]};
            default: wide_s = 9'd0;
        endcase
    end

    assign ALU_Out = wide_s[7:0];
    assign Cout    = wide_s[8];
    assign Zero    = (wide_s[7:0] == 8'd0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. With both requests pending, the side that did
// not win the last accepted grant wins; a lone request always wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;

    // One-hot grant, only while the owner is able to accept.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end else begin
            grant_o = 2'b00;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept_i) begin
            last_grant_q <= grant_o[1];
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU_8bit between two valid/ready requesters: IDLE arbitrates and
// latches operands, EXEC captures the ALU result, RESP holds it until consumed.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [2:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             busy,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt
);

    state_e           state_q;
    logic [7:0]       a_q, b_q, result_q;
    logic [2:0]       sel_q;
    logic             id_q, zero_q, carry_q;
    logic [CNT_W-1:0] done0_q, done1_q;
    logic [1:0]       grant_s;
    logic             accept_s, idle_s;
    logic [7:0]       alu_out_s;
    logic             alu_zero_s, alu_cout_s;

    // Ready is gated by rst_n so both readies read 0 while reset is held.
    assign idle_s   = (state_q == IDLE) && rst_n;
    assign accept_s = (grant_s[0] && req0_valid) || (grant_s[1] && req1_valid);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (idle_s),
        .valid_i  ({req1_valid, req0_valid}),
        .accept_i (accept_s),
        .grant_o  (grant_s)
    );

    ALU_8bit u_alu (
        .A       (a_q),
        .B       (b_q),
        .ALU_Sel (sel_q),
        .ALU_Out (alu_out_s),
        .Zero    (alu_zero_s),
        .Cout    (alu_cout_s)
    );

    // Sequencer: operand capture, result capture and completion counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            sel_q    <= 3'd0;
            id_q     <= 1'b0;
            result_q <= 8'd0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done0_q  <= '0;
            done1_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_q     <= grant_s[1] ? req1_a   : req0_a;
                        b_q     <= grant_s[1] ? req1_b   : req0_b;
                        sel_q   <= grant_s[1] ? req1_sel : req0_sel;
                        id_q    <= grant_s[1] ? ID_REQ1  : ID_REQ0;
                        state_q <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    result_q <= alu_out_s;
                    zero_q   <= alu_zero_s;
                    carry_q  <= alu_cout_s;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (id_q == ID_REQ1) begin
                            if (!(&done1_q)) done1_q <= done1_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            if (!(&done0_q)) done0_q <= done0_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state_q <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_carry  = carry_q;
    assign done0_cnt  = done0_q;
    assign done1_cnt  = done1_q;

endmodule
